// File: rtl/wb_commit_pkg.sv
// Shared widths, zero constants, load funct3 codes and FSM encoding for the writeback/commit stage.
// Also holds the load legality check shared by the commit FSM and any future LSU bypass.
package wb_commit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_WIDTH  = 5;

  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;
  localparam logic [REG_WIDTH-1:0]  ZERO_REG  = '0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  // A load is dropped when its funct3 is not a load code or its address is misaligned.
  function automatic logic load_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = addr_lo[0];
      F3_LW:         bad = (addr_lo != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load data alignment: selects the byte/half/word from an aligned memory word
// and sign- or zero-extends it according to funct3.
module wb_load_align
  import wb_commit_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign w_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      F3_LH:   data = {{(DATA_W-16){w_half[15]}}, w_half};
      F3_LW:   data = rdata;
      F3_LBU:  data = {{(DATA_W-8){1'b0}}, w_byte};
      F3_LHU:  data = {{(DATA_W-16){1'b0}}, w_half};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: retires MEM ops one at a time onto the register file write port,
// holding off upstream while a load waits for data. Optional retire counter: WB_RETIRE_CNT_EN.
//
// state    | meaning
// IDLE     | accepting ops; non-loads retire next cycle
// WAIT_MEM | load accepted, waiting for mem_rvalid; upstream stalled
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int REG_AW = REG_WIDTH
`ifdef WB_RETIRE_CNT_EN
  , parameter int CNT_W = 64
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wr_en,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_addr_lo,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_req,
  output logic              write_op,
  output logic [REG_AW-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              load_err
`ifdef WB_RETIRE_CNT_EN
  , output logic [CNT_W-1:0] retire_cnt
`endif
);

  wb_state_e         r_state, w_state_nxt;
  logic [REG_AW-1:0] r_rd;
  logic              r_wr_en;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;

  logic              w_xfer;
  logic              w_wop_nxt, w_err_nxt;
  logic [REG_AW-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt, w_aligned;

  assign in_ready  = (r_state == IDLE);
  assign stall_req = (r_state == WAIT_MEM);
  assign w_xfer    = in_valid && in_ready;

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .funct3  (r_funct3),
    .addr_lo (r_addr_lo),
    .rdata   (mem_rdata),
    .data    (w_aligned)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      write_op   <= 1'b0;
      write_addr <= ZERO_REG;
      write_data <= ZERO_WORD;
      load_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      write_op   <= w_wop_nxt;
      write_addr <= w_addr_nxt;
      write_data <= w_data_nxt;
      load_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wop_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_addr_nxt  = write_addr;
    w_data_nxt  = write_data;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (!in_is_load) begin
            w_wop_nxt  = in_wr_en && (in_rd != '0);
            w_addr_nxt = in_rd;
            w_data_nxt = in_result;
          end else if (load_bad(in_funct3, in_addr_lo)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          w_wop_nxt   = r_wr_en && (r_rd != '0);
          w_addr_nxt  = r_rd;
          w_data_nxt  = w_aligned;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Load context is captured on every load transfer, even ones that get dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd      <= '0;
      r_wr_en   <= 1'b0;
      r_funct3  <= '0;
      r_addr_lo <= '0;
    end else if (w_xfer && in_is_load) begin
      r_rd      <= in_rd;
      r_wr_en   <= in_wr_en;
      r_funct3  <= in_funct3;
      r_addr_lo <= in_addr_lo;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_retire_cnt;

  assign w_retire = (w_xfer && !in_is_load) || (stall_req && mem_rvalid);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_retire_cnt <= '0;
    else if (w_retire) r_retire_cnt <= r_retire_cnt + 1'b1;
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule
